// File: rtl/f1_axil_wr_join_pkg.sv
// Shared types, response codes and default buffer depths for the AXI-Lite write join.
package AOSF1Types;

    localparam int F1_AXIL_wr_addr_FIFO_Depth = 2;
    localparam int F1_AXIL_wr_data_FIFO_Depth = 2;

    localparam int AW_FIFO_DEPTH_DEFAULT = F1_AXIL_wr_addr_FIFO_Depth;
    localparam int W_FIFO_DEPTH_DEFAULT  = F1_AXIL_wr_data_FIFO_Depth;

    localparam logic [1:0] BRESP_OKAY   = 2'b00;
    localparam logic [1:0] BRESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } wr_state_e;

    // A depth-1 buffer still needs a one-bit pointer.
    function automatic int fifo_ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/f1_axil_wr_join_sync_fifo.sv
// Single-clock FIFO with full/empty flags; push and pop may happen in the same cycle.
module f1_axil_sync_fifo
    import AOSF1Types::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PW = fifo_ptr_w(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign data_o  = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = do_pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + CW'(1);
        end else if (!do_push && do_pop) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/f1_axil_wr_join.sv
// Joins buffered AXI-Lite AW and W beats into one SoftReg write at a time.
// Optional F1_AXIL_WSTRB_CHECK_EN: partial-strobe writes answer SLVERR without issuing.
module f1_axil_wr_join
    import AOSF1Types::*;
#(
    parameter int AW_FIFO_DEPTH = AW_FIFO_DEPTH_DEFAULT,
    parameter int W_FIFO_DEPTH  = W_FIFO_DEPTH_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        awvalid,
    output logic        awready,
    input  logic [31:0] awaddr,
    input  logic        wvalid,
    output logic        wready,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    output logic        bvalid,
    input  logic        bready,
    output logic [1:0]  bresp,
    output logic        sr_req_valid,
    input  logic        sr_req_ready,
    output logic [31:0] sr_req_addr,
    output logic [63:0] sr_req_data,
    output logic        sr_req_isWrite,
    output logic [31:0] wr_count
);

    localparam int AW_D = (AW_FIFO_DEPTH < 1) ? 1 : AW_FIFO_DEPTH;
    localparam int W_D  = (W_FIFO_DEPTH < 1) ? 1 : W_FIFO_DEPTH;

    logic        aw_full, aw_empty, w_full, w_empty;
    logic [31:0] aw_head;
    logic [35:0] w_head;
    logic        pair_pop;
    logic        strb_err;

    wr_state_e   state_q;
    logic [31:0] addr_q;
    logic [31:0] data_q;
    logic        req_vld_q;
    logic        bvld_q;
    logic [1:0]  bresp_q;
    logic [31:0] wr_count_q, wr_count_d;

    f1_axil_sync_fifo #(
        .WIDTH (32),
        .DEPTH (AW_D)
    ) u_aw_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (awvalid),
        .data_i  (awaddr),
        .pop_i   (pair_pop),
        .data_o  (aw_head),
        .full_o  (aw_full),
        .empty_o (aw_empty)
    );

    f1_axil_sync_fifo #(
        .WIDTH (36),
        .DEPTH (W_D)
    ) u_w_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (wvalid),
        .data_i  ({wstrb, wdata}),
        .pop_i   (pair_pop),
        .data_o  (w_head),
        .full_o  (w_full),
        .empty_o (w_empty)
    );

    // Ready is forced low while reset is held so the bus sees no acceptance.
    assign awready = !aw_full && !rst;
    assign wready  = !w_full && !rst;

    assign pair_pop   = (state_q == ST_IDLE) && !aw_empty && !w_empty;
    assign wr_count_d = wr_count_q + 32'd1;

`ifdef F1_AXIL_WSTRB_CHECK_EN
    assign strb_err = (w_head[35:32] != 4'hF);
`else
    logic unused_strb;
    assign unused_strb = ^w_head[35:32];
    assign strb_err    = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            data_q     <= '0;
            req_vld_q  <= 1'b0;
            bvld_q     <= 1'b0;
            bresp_q    <= BRESP_OKAY;
            wr_count_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (pair_pop) begin
                        addr_q <= aw_head;
                        data_q <= w_head[31:0];
                        if (strb_err) begin
                            bvld_q  <= 1'b1;
                            bresp_q <= BRESP_SLVERR;
                            state_q <= ST_RESP;
                        end else begin
                            req_vld_q <= 1'b1;
                            bresp_q   <= BRESP_OKAY;
                            state_q   <= ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (sr_req_ready) begin
                        req_vld_q <= 1'b0;
                        bvld_q    <= 1'b1;
                        state_q   <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (bready) begin
                        bvld_q     <= 1'b0;
                        wr_count_q <= wr_count_d;
                        state_q    <= ST_IDLE;
                    end
                end
                default: begin
                    req_vld_q <= 1'b0;
                    bvld_q    <= 1'b0;
                    state_q   <= ST_IDLE;
                end
            endcase
        end
    end

    assign sr_req_valid   = req_vld_q;
    assign sr_req_isWrite = req_vld_q;
    assign sr_req_addr    = addr_q;
    assign sr_req_data    = {32'h0, data_q};
    assign bvalid         = bvld_q;
    assign bresp          = bresp_q;
    assign wr_count       = wr_count_q;

endmodule

// File: tb/tb_f1_axil_wr_join.sv
// Randomized self-checking bench for f1_axil_wr_join against a pairing reference model.
module tb_f1_axil_wr_join;

    logic        clk = 1'b0;
    logic        rst;
    logic        awvalid, awready, wvalid, wready;
    logic [31:0] awaddr, wdata;
    logic [3:0]  wstrb;
    logic        bvalid, bready;
    logic [1:0]  bresp;
    logic        sr_req_valid, sr_req_ready, sr_req_isWrite;
    logic [31:0] sr_req_addr;
    logic [63:0] sr_req_data;
    logic [31:0] wr_count;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    logic [31:0] aw_src[$];
    logic [35:0] w_src[$];
    int          aw_gap = 0, w_gap = 0;
    bit          rdy_rand = 0, brdy_rand = 0;
    bit          rdy_fixed = 1, brdy_fixed = 1;
    bit          aw_fire = 0, w_fire = 0;

    logic [31:0] acc_aw[$];
    logic [35:0] acc_w[$];
    logic [31:0] obs_addr[$];
    logic [63:0] obs_data[$];
    logic [1:0]  obs_b[$];
    int          aw_cyc, w_cyc, req_cyc, b_cyc, iswr_bad;

    logic [31:0] exp_addr[$];
    logic [63:0] exp_data[$];
    logic [1:0]  exp_b[$];

    f1_axil_wr_join dut (
        .clk            (clk),
        .rst            (rst),
        .awvalid        (awvalid),
        .awready        (awready),
        .awaddr         (awaddr),
        .wvalid         (wvalid),
        .wready         (wready),
        .wdata          (wdata),
        .wstrb          (wstrb),
        .bvalid         (bvalid),
        .bready         (bready),
        .bresp          (bresp),
        .sr_req_valid   (sr_req_valid),
        .sr_req_ready   (sr_req_ready),
        .sr_req_addr    (sr_req_addr),
        .sr_req_data    (sr_req_data),
        .sr_req_isWrite (sr_req_isWrite),
        .wr_count       (wr_count)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Drivers update just after the rising edge; valid is held until accepted.
    initial begin
        awvalid = 0; awaddr = 0; wvalid = 0; wdata = 0; wstrb = 0;
        sr_req_ready = 0; bready = 0;
        forever begin
            @(posedge clk);
            #1;
            if (aw_fire && aw_src.size() > 0) void'(aw_src.pop_front());
            if (w_fire && w_src.size() > 0) void'(w_src.pop_front());
            if (!(awvalid && !aw_fire && aw_src.size() > 0)) begin
                awvalid = (aw_src.size() > 0) && ($urandom_range(99) >= aw_gap);
            end
            awaddr = (aw_src.size() > 0) ? aw_src[0] : 32'h0;
            if (!(wvalid && !w_fire && w_src.size() > 0)) begin
                wvalid = (w_src.size() > 0) && ($urandom_range(99) >= w_gap);
            end
            {wstrb, wdata} = (w_src.size() > 0) ? w_src[0] : 36'h0;
            sr_req_ready = rdy_rand ? ($urandom_range(1) != 0) : rdy_fixed;
            bready       = brdy_rand ? ($urandom_range(1) != 0) : brdy_fixed;
        end
    end

    // Monitor samples on the falling edge, when everything is settled.
    initial begin
        forever begin
            @(negedge clk);
            aw_fire = awvalid && awready;
            w_fire  = wvalid && wready;
            if (aw_fire) begin
                acc_aw.push_back(awaddr);
                if (aw_cyc < 0) aw_cyc = cyc;
            end
            if (w_fire) begin
                acc_w.push_back({wstrb, wdata});
                if (w_cyc < 0) w_cyc = cyc;
            end
            if (sr_req_valid && req_cyc < 0) req_cyc = cyc;
            if (sr_req_valid !== sr_req_isWrite) iswr_bad++;
            if (sr_req_valid && sr_req_ready) begin
                obs_addr.push_back(sr_req_addr);
                obs_data.push_back(sr_req_data);
            end
            if (bvalid && b_cyc < 0) b_cyc = cyc;
            if (bvalid && bready) obs_b.push_back(bresp);
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation time exhausted");
        $fatal(1, "bench timeout");
    end

    task automatic clear_mon();
        acc_aw.delete(); acc_w.delete();
        obs_addr.delete(); obs_data.delete(); obs_b.delete();
        aw_cyc = -1; w_cyc = -1; req_cyc = -1; b_cyc = -1; iswr_bad = 0;
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic wait_b(input int n, input int budget, output bit timed_out);
        int k = 0;
        while (obs_b.size() < n && k < budget) begin
            tick(1);
            k++;
        end
        timed_out = (obs_b.size() < n);
    endtask

    // Reference: i-th accepted AW pairs with i-th accepted W, strictly in order.
    task automatic build_expected();
        int n;
        exp_addr.delete(); exp_data.delete(); exp_b.delete();
        n = (acc_aw.size() < acc_w.size()) ? acc_aw.size() : acc_w.size();
        for (int i = 0; i < n; i++) begin
`ifdef F1_AXIL_WSTRB_CHECK_EN
            if (acc_w[i][35:32] != 4'hF) begin
                exp_b.push_back(2'b10);
                continue;
            end
`endif
            exp_addr.push_back(acc_aw[i]);
            exp_data.push_back({32'h0, acc_w[i][31:0]});
            exp_b.push_back(2'b00);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #1 rst = 1'b1;
        clear_mon();
        tick(3);
        checks++;
        if ({awready, wready, bvalid, sr_req_valid, sr_req_isWrite} !== 5'b0) begin
            failures++;
            $display("FAIL reset_flags: got=%b want=00000",
                     {awready, wready, bvalid, sr_req_valid, sr_req_isWrite});
        end
        checks++;
        if ({bresp, sr_req_addr, sr_req_data, wr_count} !== '0) begin
            failures++;
            $display("FAIL reset_values: bresp=%h addr=%h data=%h count=%h want all 0",
                     bresp, sr_req_addr, sr_req_data, wr_count);
        end
        rst = 1'b0;
        #1;
        checks++;
        if ({awready, wready} !== 2'b11) begin
            failures++;
            $display("FAIL reset_release_ready: got=%b want=11", {awready, wready});
        end
        tick(1);
    endtask

    task automatic test_single();
        bit to;
        logic [31:0] wc0;
        clear_mon();
        wc0 = wr_count;
        aw_src.push_back(32'h10);
        w_src.push_back({4'hF, 32'hDEADBEEF});
        wait_b(1, 30, to);
        checks++;
        if (to) begin failures++; $display("FAIL single_timeout: responses=%0d want=1", obs_b.size()); end
        checks++;
        if (req_cyc - aw_cyc != 2 || aw_cyc != w_cyc) begin
            failures++;
            $display("FAIL single_latency: aw=%0d w=%0d req=%0d want req=aw+2", aw_cyc, w_cyc, req_cyc);
        end
        checks++;
        if (obs_addr.size() != 1 || obs_addr[0] !== 32'h10 || obs_data[0] !== 64'h00000000DEADBEEF) begin
            failures++;
            $display("FAIL single_req: n=%0d addr=%h data=%h want 1/00000010/00000000deadbeef",
                     obs_addr.size(), obs_addr.size() > 0 ? obs_addr[0] : 32'hx,
                     obs_data.size() > 0 ? obs_data[0] : 64'hx);
        end
        checks++;
        if (b_cyc - aw_cyc != 3 || obs_b[0] !== 2'b00) begin
            failures++;
            $display("FAIL single_resp: bcyc=%0d aw=%0d resp=%b want aw+3/00", b_cyc, aw_cyc, obs_b[0]);
        end
        checks++;
        if (wr_count !== wc0 + 32'd1) begin
            failures++;
            $display("FAIL single_count: got=%0d want=%0d", wr_count, wc0 + 32'd1);
        end
    endtask

    task automatic test_w_delayed();
        bit to;
        logic [31:0] d;
        clear_mon();
        d = $urandom;
        aw_src.push_back(32'h20);
        tick(10);
        checks++;
        if (req_cyc >= 0 || sr_req_valid !== 1'b0) begin
            failures++;
            $display("FAIL wdelay_early_req: reqcyc=%0d valid=%b want none", req_cyc, sr_req_valid);
        end
        w_src.push_back({4'hF, d});
        wait_b(1, 30, to);
        checks++;
        if (to || req_cyc - w_cyc != 2 || w_cyc - aw_cyc < 10) begin
            failures++;
            $display("FAIL wdelay_latency: aw=%0d w=%0d req=%0d timeout=%0d want req=w+2", aw_cyc, w_cyc, req_cyc, to);
        end
        checks++;
        if (obs_addr.size() != 1 || obs_addr[0] !== 32'h20 || obs_data[0] !== {32'h0, d}) begin
            failures++;
            $display("FAIL wdelay_pair: addr=%h data=%h want 00000020/%h",
                     obs_addr.size() > 0 ? obs_addr[0] : 32'hx, obs_data.size() > 0 ? obs_data[0] : 64'hx, {32'h0, d});
        end
    endtask

    task automatic test_aw_backpressure();
        bit to;
        logic [31:0] want_addr [3];
        want_addr[0] = 32'h20; want_addr[1] = 32'h24; want_addr[2] = 32'h28;
        clear_mon();
        rdy_fixed = 0;
        for (int i = 0; i < 3; i++) aw_src.push_back(want_addr[i]);
        tick(8);
        checks++;
        if (acc_aw.size() != 2 || awready !== 1'b0) begin
            failures++;
            $display("FAIL bp_aw_full: accepted=%0d awready=%b want 2/0", acc_aw.size(), awready);
        end
        for (int i = 0; i < 3; i++) w_src.push_back({4'hF, 32'($urandom)});
        tick(8);
        checks++;
        if (obs_addr.size() != 0 || sr_req_valid !== 1'b1) begin
            failures++;
            $display("FAIL bp_stall: issued=%0d valid=%b want 0/1", obs_addr.size(), sr_req_valid);
        end
        rdy_fixed = 1;
        wait_b(3, 40, to);
        build_expected();
        checks++;
        if (to || obs_addr.size() != 3) begin
            failures++;
            $display("FAIL bp_count: issued=%0d want=3", obs_addr.size());
        end
        for (int i = 0; i < 3 && i < obs_addr.size(); i++) begin
            checks++;
            if (obs_addr[i] !== want_addr[i] || obs_data[i] !== exp_data[i]) begin
                failures++;
                $display("FAIL bp_order[%0d]: addr=%h data=%h want %h/%h", i, obs_addr[i], obs_data[i],
                         want_addr[i], exp_data[i]);
            end
        end
    endtask

    task automatic test_wstrb();
        bit to;
        logic [31:0] wc0;
        logic [1:0]  want_resp;
        int          want_reqs;
        clear_mon();
        wc0 = wr_count;
        aw_src.push_back(32'h30);
        w_src.push_back({4'h3, 32'h12345678});
`ifdef F1_AXIL_WSTRB_CHECK_EN
        want_resp = 2'b10;
        want_reqs = 0;
`else
        want_resp = 2'b00;
        want_reqs = 1;
`endif
        wait_b(1, 30, to);
        checks++;
        if (to || obs_b[0] !== want_resp) begin
            failures++;
            $display("FAIL wstrb_resp: got=%b want=%b timeout=%0d", obs_b[0], want_resp, to);
        end
        checks++;
        if (obs_addr.size() != want_reqs) begin
            failures++;
            $display("FAIL wstrb_issue: issued=%0d want=%0d", obs_addr.size(), want_reqs);
        end
        checks++;
        if (wr_count !== wc0 + 32'd1) begin
            failures++;
            $display("FAIL wstrb_count: got=%0d want=%0d", wr_count, wc0 + 32'd1);
        end
    endtask

    task automatic test_random();
        bit to;
        logic [31:0] wc0;
        localparam int N = 40;
        clear_mon();
        wc0 = wr_count;
        rdy_rand = 1; brdy_rand = 1; aw_gap = 30; w_gap = 30;
        for (int i = 0; i < N; i++) begin
            aw_src.push_back({$urandom} & 32'hFFFF_FFFC);
            w_src.push_back({($urandom_range(3) == 0) ? 4'($urandom_range(14)) : 4'hF, 32'($urandom)});
        end
        wait_b(N, 3000, to);
        rdy_rand = 0; brdy_rand = 0; aw_gap = 0; w_gap = 0;
        tick(2);
        build_expected();
        checks++;
        if (to || obs_b.size() != exp_b.size() || obs_addr.size() != exp_addr.size()) begin
            failures++;
            $display("FAIL rand_counts: resp=%0d/%0d req=%0d/%0d", obs_b.size(), exp_b.size(),
                     obs_addr.size(), exp_addr.size());
        end
        for (int i = 0; i < exp_addr.size() && i < obs_addr.size(); i++) begin
            checks++;
            if (obs_addr[i] !== exp_addr[i] || obs_data[i] !== exp_data[i]) begin
                failures++;
                $display("FAIL rand_req[%0d]: got=%h/%h want=%h/%h", i, obs_addr[i], obs_data[i],
                         exp_addr[i], exp_data[i]);
            end
        end
        for (int i = 0; i < exp_b.size() && i < obs_b.size(); i++) begin
            checks++;
            if (obs_b[i] !== exp_b[i]) begin
                failures++;
                $display("FAIL rand_resp[%0d]: got=%b want=%b", i, obs_b[i], exp_b[i]);
            end
        end
        checks++;
        if (wr_count !== wc0 + 32'(N) || iswr_bad != 0) begin
            failures++;
            $display("FAIL rand_count: got=%0d want=%0d iswrite_errors=%0d", wr_count, wc0 + 32'(N), iswr_bad);
        end
    endtask

    task automatic test_reset_mid();
        int k = 0;
        clear_mon();
        rdy_fixed = 0;
        for (int i = 0; i < 2; i++) begin
            aw_src.push_back(32'h100 + 32'(i * 4));
            w_src.push_back({4'hF, 32'($urandom)});
        end
        while (!sr_req_valid && k < 30) begin
            tick(1);
            k++;
        end
        tick(3);
        checks++;
        if (sr_req_valid !== 1'b1 || dut.aw_empty !== 1'b0 || dut.w_empty !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_setup: valid=%b aw_empty=%b w_empty=%b want 1/0/0",
                     sr_req_valid, dut.aw_empty, dut.w_empty);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (sr_req_valid !== 1'b0 || bvalid !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_outputs: valid=%b bvalid=%b want 0/0", sr_req_valid, bvalid);
        end
        checks++;
        if (dut.aw_empty !== 1'b1 || dut.w_empty !== 1'b1 || wr_count !== 32'd0) begin
            failures++;
            $display("FAIL rstmid_state: aw_empty=%b w_empty=%b count=%0d want 1/1/0",
                     dut.aw_empty, dut.w_empty, wr_count);
        end
        aw_src.delete(); w_src.delete();
        clear_mon();
        tick(2);
        rst = 1'b0;
        #1;
        checks++;
        if ({awready, wready} !== 2'b11) begin
            failures++;
            $display("FAIL rstmid_ready: got=%b want=11", {awready, wready});
        end
        rdy_fixed = 1;
        tick(15);
        checks++;
        if (obs_addr.size() != 0 || obs_b.size() != 0 || wr_count !== 32'd0) begin
            failures++;
            $display("FAIL rstmid_silence: req=%0d resp=%0d count=%0d want 0/0/0",
                     obs_addr.size(), obs_b.size(), wr_count);
        end
    endtask

    task automatic test_wrap();
        bit to;
        clear_mon();
        force dut.wr_count_q = 32'hFFFF_FFFF;
        tick(1);
        release dut.wr_count_q;
        tick(1);
        checks++;
        if (wr_count !== 32'hFFFF_FFFF) begin
            failures++;
            $display("FAIL wrap_preload: got=%h want=ffffffff", wr_count);
        end
        aw_src.push_back(32'h44);
        w_src.push_back({4'hF, 32'hCAFEF00D});
        wait_b(1, 30, to);
        checks++;
        if (to || wr_count !== 32'd0) begin
            failures++;
            $display("FAIL wrap_count: got=%h want=00000000 timeout=%0d", wr_count, to);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_w_delayed();
        test_aw_backpressure();
        test_wstrb();
        test_random();
        test_reset_mid();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/f1_axil_wr_join.md
F1_AXIL_WR_JOIN -- requirements
Module: f1_axil_wr_join

Interface
REQ-001 The block SHALL have parameter AW_FIFO_DEPTH, default 2, which sets the AW buffer entries (minimum 1).
REQ-002 The block SHALL have parameter W_FIFO_DEPTH, default 2, which sets the W buffer entries (minimum 1).
REQ-003 clk  in  1  sole clock; all logic is rising-edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 awvalid/awready  in/out  1/1  AXI-Lite write-address handshake; awaddr  in  32  byte address.
REQ-006 wvalid/wready  in/out  1/1  AXI-Lite write-data handshake; wdata  in  32  data; wstrb  in  4  byte strobes.
REQ-007 bvalid/bready  out/in  1/1  write-response handshake; bresp  out  2  response code.
REQ-008 sr_req_valid  out  1  SoftReg write request valid; sr_req_ready  in  1  downstream accept.
REQ-009 sr_req_addr  out  32  request address; sr_req_data  out  64  request data; sr_req_isWrite  out  1  request type, constant 1 while valid.
REQ-010 wr_count  out  32  number of completed B handshakes.

Function
REQ-011 AW and W SHALL each be buffered in an independent FIFO; awready = !aw_full; wready = !w_full; there SHALL be no bypass path and no push when full.
REQ-012 The FSM SHALL have three states: IDLE, ISSUE and RESP, with exactly one transaction in flight.
REQ-013 In IDLE, when both FIFOs are non-empty, the block SHALL pop one entry from each in the same cycle, latch addr/data/strb, and go to ISSUE.
REQ-014 In IDLE, when only one FIFO is non-empty, the block SHALL pop nothing and hold the entry indefinitely.
REQ-015 In ISSUE, sr_req_valid SHALL be 1, and addr/data SHALL be stable until the cycle sr_req_ready=1, then go to RESP.
REQ-016 In RESP, bvalid SHALL be 1 and bresp stable until bready=1, then return to IDLE and increment wr_count (wraps 0xFFFFFFFF->0).
REQ-017 sr_req_addr SHALL equal awaddr unmodified; sr_req_data SHALL be {32'h0, wdata}.
REQ-018 With AW and W accepted in cycle 0, sr_req_valid SHALL first assert in cycle 2; the minimum transaction period is 3 cycles (ready held high).
REQ-019 Pushes into the FIFOs SHALL proceed during ISSUE/RESP while not full; order is strictly FIFO per channel.
REQ-020 A same-cycle push and pop on one FIFO SHALL be legal and leave its occupancy unchanged.
REQ-021 bresp SHALL be 2'b00 (OKAY) unless REQ-025 applies.

Reset
REQ-022 While rst=1, the block SHALL keep the FSM in IDLE and both FIFOs empty, and drive every output to 0 (awready, wready, bvalid, bresp, sr_req_valid, sr_req_addr, sr_req_data, sr_req_isWrite, wr_count).
REQ-023 The first cycle after rst deasserts SHALL have awready=wready=1.
REQ-024 Reset mid-transaction SHALL discard the in-flight and all buffered writes, issue no SoftReg request and no B response for them, and leave wr_count at 0.

Configuration
REQ-025 With F1_AXIL_WSTRB_CHECK_EN defined, a popped pair with wstrb!=4'hF SHALL skip ISSUE (IDLE->RESP directly) with bresp=2'b10 (SLVERR) and still increment wr_count.
REQ-026 Without F1_AXIL_WSTRB_CHECK_EN, wstrb SHALL be ignored, and every write SHALL be issued with bresp=OKAY.

Structure
REQ-027 The shared package AOSF1Types SHALL hold the FSM state enum, the BRESP_OKAY/BRESP_SLVERR constants, and the default depths, tied to F1_AXIL_wr_addr_FIFO_Depth and F1_AXIL_wr_data_FIFO_Depth.
REQ-028 The two FIFOs SHALL be instances of one sub-module, f1_axil_sync_fifo (WIDTH, DEPTH parameters; full/empty flags; same-cycle push/pop).

Verification
REQ-029 AW addr 0x10 and W data 0xDEADBEEF, same cycle, ready held high -> sr_req_valid in cycle 2 with addr 0x10, data 0x00000000DEADBEEF; bvalid in cycle 3 with OKAY; wr_count=1.
REQ-030 AW only (addr 0x20), W delayed 10 cycles -> no sr_req_valid until 2 cycles after W accepted; pairing is correct.
REQ-031 Three AWs back-to-back with sr_req_ready=0 -> awready falls after 2 accepted (depth 2); data order 0x20,0x24,0x28 is preserved after ready rises.
REQ-032 Macro defined, wstrb=4'h3 -> no sr_req_valid, bresp=2'b10, wr_count increments; macro undefined -> issued normally with OKAY.
REQ-033 rst pulsed while in ISSUE with one more pair buffered -> sr_req_valid=0 and bvalid=0 immediately; FIFOs empty; wr_count=0; no later response.
REQ-034 Preload wr_count via 2^32-1 forced transactions (or force) and complete one more -> wr_count wraps to 0.
